// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of one shared signed BITSIZE x BITSIZE multiplier.
// Pipeline: operand capture at grant, full product register, truncated result with valid.
module mult_arbiter #(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned NREQ    = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    sync,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*BITSIZE-1:0] in1,
  input  logic [NREQ*BITSIZE-1:0] in2,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         valid,
  output logic [BITSIZE-1:0]      out,
  output logic                    busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]            r_p;
  logic [IW-1:0]            w_base;
  logic [IW-1:0]            w_cand;
  logic [IW-1:0]            w_win;
  logic [IW-1:0]            w_p_next;
  logic                     w_found;
  logic [NREQ-1:0]          w_elig;
  logic [NREQ-1:0]          r_gnt;

  logic                     r_s1_vld;
  logic [IW-1:0]            r_s1_idx;
  logic [BITSIZE-1:0]       r_a;
  logic [BITSIZE-1:0]       r_b;

  logic                     r_s2_vld;
  logic [IW-1:0]            r_s2_idx;
  logic signed [2*BITSIZE-1:0] r_prod;
  logic signed [2*BITSIZE-1:0] w_a_ext;
  logic signed [2*BITSIZE-1:0] w_b_ext;
  logic signed [2*BITSIZE-1:0] w_prod;

  logic [NREQ-1:0]          r_valid;
  logic [BITSIZE-1:0]       r_out;
  logic                     w_unused_lo;

  // The requester granted last edge sits out exactly one arbitration round.
  assign w_elig = req & ~r_gnt;
  assign w_base = sync ? '0 : r_p;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = IW'((32'(w_base) + k) % NREQ);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    if (w_found) begin
      w_p_next = IW'((32'(w_win) + 32'd1) % NREQ);
    end else if (sync) begin
      w_p_next = '0;
    end else begin
      w_p_next = r_p;
    end
  end

  assign w_a_ext = {{BITSIZE{r_a[BITSIZE-1]}}, r_a};
  assign w_b_ext = {{BITSIZE{r_b[BITSIZE-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Low half of the product is kept in the stage register but never reaches out.
  assign w_unused_lo = ^r_prod[BITSIZE-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_p      <= '0;
      r_gnt    <= '0;
      r_s1_vld <= 1'b0;
      r_s1_idx <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_p      <= w_p_next;
      r_gnt    <= w_found ? (NREQ'(1) << w_win) : '0;
      r_s1_vld <= w_found;
      if (w_found) begin
        r_s1_idx <= w_win;
        r_a      <= in1[32'(w_win)*BITSIZE +: BITSIZE];
        r_b      <= in2[32'(w_win)*BITSIZE +: BITSIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s2_vld <= 1'b0;
      r_s2_idx <= '0;
      r_prod   <= '0;
      r_valid  <= '0;
      r_out    <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_idx <= r_s1_idx;
        r_prod   <= w_prod;
      end
      r_valid <= r_s2_vld ? (NREQ'(1) << r_s2_idx) : '0;
      if (r_s2_vld) begin
        r_out <= r_prod[2*BITSIZE-1 -: BITSIZE];
      end
    end
  end

  assign gnt   = r_gnt;
  assign valid = r_valid;
  assign out   = r_out;
  assign busy  = (|req) | r_s1_vld | r_s2_vld;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed vectors and sequences plus random traffic
// checked against a queue-based reference model of the arbiter and pipeline.
module tb_mult_arbiter;
  localparam int unsigned BITSIZE = 16;
  localparam int unsigned NREQ    = 4;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic                    sync;
  logic [NREQ-1:0]         req;
  logic [NREQ*BITSIZE-1:0] in1;
  logic [NREQ*BITSIZE-1:0] in2;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         valid;
  logic [BITSIZE-1:0]      out;
  logic                    busy;

  mult_arbiter #(
    .BITSIZE(BITSIZE),
    .NREQ   (NREQ)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .sync  (sync),
    .req   (req),
    .in1   (in1),
    .in2   (in2),
    .gnt   (gnt),
    .valid (valid),
    .out   (out),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int                 due;
    int                 idx;
    logic [BITSIZE-1:0] res;
  } pend_t;

  typedef struct {
    logic [BITSIZE-1:0] a;
    logic [BITSIZE-1:0] b;
    logic [BITSIZE-1:0] exp_out;
  } vec_t;

  pend_t              m_q[$];
  int                 m_p;
  int                 m_n;
  logic [NREQ-1:0]    m_gnt;
  logic [NREQ-1:0]    m_valid;
  logic [BITSIZE-1:0] m_out;

  vec_t               vecs[4];
  logic [NREQ-1:0]    gseq[7];
  logic [BITSIZE-1:0] corners[5];

  function automatic logic [BITSIZE-1:0] ref_mul(input logic [BITSIZE-1:0] a,
                                                 input logic [BITSIZE-1:0] b);
    longint pa;
    pa = longint'($signed(a)) * longint'($signed(b));
    return BITSIZE'(pa >>> BITSIZE);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the current inputs to the model as if a rising edge happened.
  task automatic model_edge();
    int base;
    int w;
    int i;
    if (!resetn) begin
      m_q.delete();
      m_p     = 0;
      m_n     = 0;
      m_gnt   = '0;
      m_valid = '0;
      m_out   = '0;
      return;
    end
    m_n++;
    m_valid = '0;
    if (m_q.size() > 0 && m_q[0].due == m_n) begin
      m_valid[m_q[0].idx] = 1'b1;
      m_out = m_q[0].res;
      void'(m_q.pop_front());
    end
    base = sync ? 0 : m_p;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (base + k) % NREQ;
      if (w < 0 && req[i] && !m_gnt[i]) w = i;
    end
    m_gnt = '0;
    if (w >= 0) begin
      m_gnt[w] = 1'b1;
      m_q.push_back('{due: m_n + 2, idx: w,
                      res: ref_mul(in1[w*BITSIZE +: BITSIZE], in2[w*BITSIZE +: BITSIZE])});
      m_p = (w + 1) % NREQ;
    end else if (sync) begin
      m_p = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("model_gnt", gnt, m_gnt);
    chk("model_valid", valid, m_valid);
    chk("model_out", out, m_out);
    chk("model_busy", busy, (|req) || (m_q.size() > 0));
  endtask

  task automatic set_ops(input int i, input logic [BITSIZE-1:0] a, input logic [BITSIZE-1:0] b);
    in1[i*BITSIZE +: BITSIZE] = a;
    in2[i*BITSIZE +: BITSIZE] = b;
  endtask

  task automatic do_reset();
    req    = '0;
    sync   = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    int cnt;
    vecs[0] = '{a: 16'h4000, b: 16'h4000, exp_out: 16'h1000};
    vecs[1] = '{a: 16'h8000, b: 16'h8000, exp_out: 16'h4000};
    vecs[2] = '{a: 16'h8000, b: 16'h7FFF, exp_out: 16'hC000};
    vecs[3] = '{a: 16'hFFFF, b: 16'h0001, exp_out: 16'hFFFF};
    gseq    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    corners = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h0000};

    resetn = 1'b0;
    sync   = 1'b0;
    req    = '0;
    in1    = '0;
    in2    = '0;
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", valid, 0);
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;

    // Single-requester multiplies, including the sign/truncation corners.
    for (int v = 0; v < 4; v++) begin
      set_ops(0, vecs[v].a, vecs[v].b);
      req = 4'b0001;
      tick();
      chk("vec_gnt", gnt, 4'b0001);
      req = 4'b0000;
      set_ops(0, 16'h1234, 16'h5678);
      tick();
      chk("vec_gnt_off", gnt, 0);
      chk("vec_valid_early", valid, 0);
      tick();
      chk("vec_valid", valid, 4'b0001);
      chk("vec_out", out, vecs[v].exp_out);
      tick();
      chk("vec_valid_off", valid, 0);
      chk("vec_out_hold", out, vecs[v].exp_out);
    end

    // All four requesting: strict rotation, results two cycles behind.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'(i + 1) << 12, 16'h2000);
    req = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("rr_gnt", gnt, gseq[k]);
      chk("rr_valid", valid, (k >= 2) ? gseq[k-2] : 4'b0000);
    end

    // Lone requester held: masked every other edge.
    do_reset();
    req = 4'b0010;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("lone_gnt", gnt, (k % 2 == 0) ? 4'b0010 : 4'b0000);
      if (gnt[1]) cnt++;
    end
    chk("lone_count", cnt, 3);

    // Sync forces the pointer back to requester 0.
    do_reset();
    req = 4'b0010;
    tick();
    chk("sync_pre_gnt", gnt, 4'b0010);
    req  = 4'b0101;
    sync = 1'b1;
    tick();
    chk("sync_gnt", gnt, 4'b0001);
    sync = 1'b0;
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b0101;
    tick();
    chk("nosync_gnt", gnt, 4'b0100);

    // Reset right after a grant must drop the in-flight operation.
    do_reset();
    set_ops(0, 16'h4000, 16'h4000);
    req = 4'b0001;
    tick();
    chk("rstf_gnt", gnt, 4'b0001);
    req    = 4'b0000;
    resetn = 1'b0;
    tick();
    chk("rstf_valid0", valid, 0);
    chk("rstf_out0", out, 0);
    chk("rstf_gnt0", gnt, 0);
    tick();
    chk("rstf_valid1", valid, 0);
    resetn = 1'b1;
    set_ops(0, 16'h2000, 16'h2000);
    req = 4'b0001;
    tick();
    chk("rstf_regnt", gnt, 4'b0001);
    chk("rstf_novalid_a", valid, 0);
    req = 4'b0000;
    tick();
    chk("rstf_novalid_b", valid, 0);
    tick();
    chk("rstf_new_valid", valid, 4'b0001);
    chk("rstf_new_out", out, 16'h0400);

    // Random traffic against the model.
    for (int c = 0; c < 500; c++) begin
      resetn = ($urandom_range(0, 99) != 0);
      req    = 4'($urandom);
      sync   = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NREQ; i++) begin
        set_ops(i,
                ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom),
                ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom));
      end
      tick();
    end

    resetn = 1'b1;
    req    = '0;
    sync   = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("drain_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
